// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the memory port arbiter
// Contents: arbiter state enum, grant-id constants, rdata value returned on timeout.
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    DONE_IF,
    DONE_DM
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  // Read data handed back when a transaction is aborted by the watchdog
  // (and for stores, whose captured data has no meaning).
  localparam int ERR_RDATA = 0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/acknowledge bus to the unified memory
// Signals: mem_req/mem_we/mem_addr/mem_wdata (arbiter to memory),
//          mem_rdata/mem_ack (memory to arbiter).
// Modports: master = arbiter side, slave = memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/arb_priority.sv
// rtl/arb_priority.sv - combinational grant selection between fetch and data ports
// Ports: if_req, dm_req, starve_full (in); gnt_id, gnt_valid (out).
module arb_priority
  import arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic starve_full,
  output logic gnt_id,
  output logic gnt_valid
);

  // DM normally wins so the older instruction completes first; once DM has
  // won DM_MAX times in a row against a waiting fetch, IF takes the slot.
  always_comb begin
    gnt_valid = if_req | dm_req;
    gnt_id    = (dm_req && !(if_req && starve_full)) ? GNT_DM : GNT_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory between IF and DM requesters
// Ports: clk, initPC_n (async active-low reset);
//        IF side: if_req, if_addr in; if_rdata, if_ready out;
//        DM side: dm_req, dm_we, dm_addr, dm_wdata in; dm_rdata, dm_ready out;
//        mem: memory bus (master modport); err: sticky latency-timeout flag.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DM_MAX  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 initPC_n,
  input  logic                 if_req,
  input  logic [AW-1:0]        if_addr,
  output logic [DW-1:0]        if_rdata,
  output logic                 if_ready,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [AW-1:0]        dm_addr,
  input  logic [DW-1:0]        dm_wdata,
  output logic [DW-1:0]        dm_rdata,
  output logic                 dm_ready,
  mem_port_arbiter_if.master   mem,
  output logic                 err
);

  localparam int SW = $clog2(DM_MAX + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(DM_MAX);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic          gnt_id;
  logic          gnt_valid;

  arb_priority u_priority (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .starve_full (starve_cnt == STARVE_MAX),
    .gnt_id      (gnt_id),
    .gnt_valid   (gnt_valid)
  );

  always_ff @(posedge clk or negedge initPC_n) begin
    if (!initPC_n) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      wait_cnt      <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      if_rdata      <= '0;
      if_ready      <= 1'b0;
      dm_rdata      <= '0;
      dm_ready      <= 1'b0;
      err           <= 1'b0;
    end else begin
      // Ready outputs are single-cycle pulses raised only on the BUSY->DONE edge.
      if_ready <= 1'b0;
      dm_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (gnt_valid) begin
            mem.mem_req <= 1'b1;
            wait_cnt    <= '0;
            if (gnt_id == GNT_DM) begin
              state         <= BUSY_DM;
              mem.mem_we    <= dm_we;
              mem.mem_addr  <= dm_addr;
              mem.mem_wdata <= dm_wdata;
              if (if_req) begin
                if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
              end else begin
                starve_cnt <= '0;
              end
            end else begin
              state         <= BUSY_IF;
              mem.mem_we    <= 1'b0;
              mem.mem_addr  <= if_addr;
              mem.mem_wdata <= '0;
              starve_cnt    <= '0;
            end
          end else begin
            // No request at all implies if_req=0, so fetch is not waiting.
            starve_cnt <= '0;
          end
        end

        BUSY_IF, BUSY_DM: begin
          // An ack in the last allowed cycle still counts as a success.
          if (mem.mem_ack || (wait_cnt == WAIT_LAST)) begin
            mem.mem_req <= 1'b0;
            if (!mem.mem_ack) err <= 1'b1;
            if (state == BUSY_IF) begin
              state    <= DONE_IF;
              if_ready <= 1'b1;
              if_rdata <= mem.mem_ack ? mem.mem_rdata : DW'(ERR_RDATA);
            end else begin
              state    <= DONE_DM;
              dm_ready <= 1'b1;
              dm_rdata <= (mem.mem_ack && !mem.mem_we) ? mem.mem_rdata : DW'(ERR_RDATA);
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // DONE states last one cycle; new requests are only looked at in IDLE,
        // which keeps a renewed same-port request from being granted twice.
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } dm_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    int          len;
  } mx_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        initPC_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        err;

  mem_port_arbiter_if #(.AW(32), .DW(32)) mem ();

  mem_port_arbiter #(.AW(32), .DW(32), .DM_MAX(4), .TIMEOUT(16)) dut (
    .clk      (clk),
    .initPC_n (initPC_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .mem      (mem),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int if_cyc  = 0;
  int dm_cyc  = 0;
  int ready_cnt = 0;
  logic stray_ack = 1'b0;

  logic [31:0] if_q[$];
  dm_t         dm_q[$];
  mx_t         mem_q[$];
  rsp_t        exp_if_q[$];
  rsp_t        exp_dm_q[$];

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_mem(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input int lat, input logic [31:0] rd, input int len);
    mx_t m;
    m.addr = a; m.we = we; m.wdata = wd; m.lat = lat; m.rdata = rd; m.len = len;
    mem_q.push_back(m);
  endtask

  task automatic push_dm(input logic [31:0] a, input logic we, input logic [31:0] wd);
    dm_t d;
    d.addr = a; d.we = we; d.wdata = wd;
    dm_q.push_back(d);
  endtask

  task automatic push_exp(input bit is_dm, input logic [31:0] rd, input logic e);
    rsp_t r;
    r.rdata = rd; r.err = e;
    if (is_dm) exp_dm_q.push_back(r);
    else exp_if_q.push_back(r);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((if_q.size() + dm_q.size() + mem_q.size() + exp_if_q.size() + exp_dm_q.size()) != 0
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_in_budget"}, 96'(n < budget), 96'(1));
    repeat (2) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // IF requester: holds the head request, drops/renews when if_ready is seen.
  initial begin
    if_req = 1'b0; if_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (if_ready && if_q.size() > 0) void'(if_q.pop_front());
      if (if_q.size() > 0) begin if_req = 1'b1; if_addr = if_q[0]; end
      else if_req = 1'b0;
    end
  end

  // DM requester.
  initial begin
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dm_ready && dm_q.size() > 0) void'(dm_q.pop_front());
      if (dm_q.size() > 0) begin
        dm_req = 1'b1; dm_we = dm_q[0].we; dm_addr = dm_q[0].addr; dm_wdata = dm_q[0].wdata;
      end else begin
        dm_req = 1'b0; dm_we = 1'b0;
      end
    end
  end

  // Memory model: checks each granted access against the expected grant order,
  // acks in the lat-th cycle of mem_req (lat=0: never), checks window length/stability.
  initial begin
    mx_t cur;
    int cnt;
    bit active;
    bit stable;
    logic [64:0] first;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
    cnt = 0; active = 0; stable = 1;
    cur.addr = '0; cur.we = 0; cur.wdata = '0; cur.lat = 1; cur.rdata = '0; cur.len = -1;
    first = '0;
    forever begin
      @(posedge clk); #1;
      if (mem.mem_req) begin
        if (!active) begin
          active = 1; cnt = 0; stable = 1;
          first = {mem.mem_addr, mem.mem_we, mem.mem_wdata};
          if (mem_q.size() == 0) begin
            chk("mem_unexpected_grant", 96'(first), 96'(0));
            cur.lat = 1; cur.rdata = '0; cur.len = -1;
          end else begin
            cur = mem_q.pop_front();
            chk("mem_grant", 96'(first), 96'({cur.addr, cur.we, cur.wdata}));
          end
        end
        cnt++;
        if ({mem.mem_addr, mem.mem_we, mem.mem_wdata} !== first) stable = 0;
        if (cur.lat != 0 && cnt == cur.lat) begin
          mem.mem_ack = 1'b1; mem.mem_rdata = cur.rdata;
        end else begin
          mem.mem_ack = 1'b0; mem.mem_rdata = 32'hBAD0BAD0;
        end
      end else begin
        if (active) begin
          active = 0;
          if (cur.len >= 0) chk("mem_window_len", 96'(cnt), 96'(cur.len));
          chk("mem_stable", 96'(stable), 96'(1));
        end
        mem.mem_ack = stray_ack;
        mem.mem_rdata = stray_ack ? 32'hFFFFFFFF : '0;
      end
    end
  end

  // Response monitor.
  initial forever begin
    rsp_t e;
    @(posedge clk); #1;
    if (if_ready || dm_ready) begin
      ready_cnt++;
      chk("ready_exclusive", 96'(if_ready & dm_ready), 96'(0));
      chk("mem_req_in_done", 96'(mem.mem_req), 96'(0));
    end
    if (if_ready) begin
      if_cyc = cyc;
      if (exp_if_q.size() == 0) chk("if_unexpected_ready", 96'(1), 96'(0));
      else begin
        e = exp_if_q.pop_front();
        chk("if_rdata", 96'(if_rdata), 96'(e.rdata));
        chk("if_err", 96'(err), 96'(e.err));
      end
    end
    if (dm_ready) begin
      dm_cyc = cyc;
      if (exp_dm_q.size() == 0) chk("dm_unexpected_ready", 96'(1), 96'(0));
      else begin
        e = exp_dm_q.pop_front();
        chk("dm_rdata", 96'(dm_rdata), 96'(e.rdata));
        chk("dm_err", 96'(err), 96'(e.err));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int d;
    int n;
    int rc;
    initPC_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 96'(mem.mem_req), 96'(0));
    chk("rst_mem_bus", 96'({mem.mem_we, mem.mem_addr, mem.mem_wdata}), 96'(0));
    chk("rst_ready", 96'({if_ready, dm_ready}), 96'(0));
    chk("rst_rdata", 96'({if_rdata, dm_rdata}), 96'(0));
    chk("rst_err", 96'(err), 96'(0));
    initPC_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single fetch, latency 3.
    if_q.push_back(32'h00400000);
    push_mem(32'h00400000, 1'b0, 32'h0, 3, 32'h8C080000, 3);
    push_exp(1'b0, 32'h8C080000, 1'b0);
    drain("single_fetch", 50);

    // Simultaneous requests: DM load first, IF three cycles later.
    if_q.push_back(32'h00400004);
    push_dm(32'h10010004, 1'b0, 32'h0);
    push_mem(32'h10010004, 1'b0, 32'h0, 1, 32'h0000002A, 1);
    push_mem(32'h00400004, 1'b0, 32'h0, 1, 32'h8C090004, 1);
    push_exp(1'b1, 32'h0000002A, 1'b0);
    push_exp(1'b0, 32'h8C090004, 1'b0);
    drain("simultaneous", 50);
    chk("dm_to_if_spacing", 96'(if_cyc - dm_cyc), 96'(3));

    // Starvation: 4 DM grants, 1 IF, 4 DM, 1 IF, then remaining DM.
    for (int i = 0; i < 10; i++) begin
      push_dm(32'h10020000 + 32'(4 * i), 1'b0, 32'h0);
      push_exp(1'b1, 32'h00000100 + 32'(i), 1'b0);
    end
    if_q.push_back(32'h00400100);
    if_q.push_back(32'h00400104);
    push_exp(1'b0, 32'h8C0A0000, 1'b0);
    push_exp(1'b0, 32'h8C0A0004, 1'b0);
    d = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) push_mem(32'h00400100, 1'b0, 32'h0, 1, 32'h8C0A0000, 1);
      else if (k == 9) push_mem(32'h00400104, 1'b0, 32'h0, 1, 32'h8C0A0004, 1);
      else begin
        push_mem(32'h10020000 + 32'(4 * d), 1'b0, 32'h0, 1, 32'h00000100 + 32'(d), 1);
        d++;
      end
    end
    drain("starvation", 200);

    // Store, latency 2: memory returns junk, dm_rdata reads 0.
    push_dm(32'h10010008, 1'b1, 32'h12345678);
    push_mem(32'h10010008, 1'b1, 32'h12345678, 2, 32'hDEADBEEF, 2);
    push_exp(1'b1, 32'h0, 1'b0);
    drain("store", 50);

    // Timeout on a fetch, then a good load still sees err=1.
    if_q.push_back(32'h00400010);
    push_mem(32'h00400010, 1'b0, 32'h0, 0, 32'h0, 16);
    push_exp(1'b0, 32'h0, 1'b1);
    drain("timeout", 100);
    push_dm(32'h10010010, 1'b0, 32'h0);
    push_mem(32'h10010010, 1'b0, 32'h0, 2, 32'h00000055, 2);
    push_exp(1'b1, 32'h00000055, 1'b1);
    drain("after_timeout", 50);
    chk("err_sticky", 96'(err), 96'(1));

    // Reset in the middle of a DM transaction.
    push_dm(32'h1001000C, 1'b0, 32'h0);
    push_mem(32'h1001000C, 1'b0, 32'h0, 0, 32'h0, -1);
    n = 0;
    while (!mem.mem_req && n < 20) begin @(negedge clk); n++; end
    chk("reset_busy_reached", 96'(n < 20), 96'(1));
    repeat (3) @(negedge clk);
    #2 initPC_n = 1'b0;
    dm_q.delete();
    #1;
    chk("midrst_mem_req", 96'(mem.mem_req), 96'(0));
    chk("midrst_ready", 96'({if_ready, dm_ready}), 96'(0));
    chk("midrst_err", 96'(err), 96'(0));
    repeat (2) @(negedge clk);
    initPC_n = 1'b1;
    rc = ready_cnt;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_ack_no_ready", 96'(ready_cnt - rc), 96'(0));
    chk("stray_ack_no_req", 96'(mem.mem_req), 96'(0));
    push_dm(32'h10010014, 1'b0, 32'h0);
    push_mem(32'h10010014, 1'b0, 32'h0, 1, 32'h00000077, 1);
    push_exp(1'b1, 32'h00000077, 1'b0);
    drain("after_reset", 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
